// File: rtl/img_buffer.sv
// Image byte-assembly buffer: collects BYTES bytes into a flat IMG_BITS image,
// holds the completed image for a downstream consumer until clear_buffer.
module img_buffer #(
  parameter int unsigned IMG_BITS = 904,
  parameter int unsigned BYTES    = IMG_BITS / 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_byte,
  input  logic                rx_valid,
  input  logic                rx_sof,
  output logic                rx_ready,
  output logic [IMG_BITS-1:0] img_out,
  output logic                img_buffer_full,
  input  logic                clear_buffer,
  output logic [6:0]          byte_count,
  output logic                sof_err
);

  typedef enum logic [1:0] {StIdle, StFill, StFull} state_e;

  state_e              state_q, state_d;
  logic [IMG_BITS-1:0] img_q, img_d;
  logic [6:0]          count_q, count_d;
  logic                sof_err_q, sof_err_d;
  logic                accept;
  logic [6:0]          wr_idx;

  // Held off during reset so nothing is taken while state is being cleared.
  assign rx_ready = ~rst & (state_q != StFull);
  // clear_buffer wins over any byte presented in the same cycle.
  assign accept   = rx_valid & rx_ready & ~clear_buffer;

  // Next-state, byte slot selection and byte counting.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    sof_err_d = sof_err_q;
    wr_idx    = '0;
    unique case (state_q)
      StIdle: begin
        if (clear_buffer) begin
          count_d = '0;
        end else if (accept) begin
          wr_idx  = '0;
          count_d = 7'd1;
          state_d = (BYTES == 1) ? StFull : StFill;
        end
      end
      StFill: begin
        if (clear_buffer) begin
          count_d = '0;
          state_d = StIdle;
        end else if (accept) begin
          if (rx_sof) begin
            // Restart mid-frame: overwrite from byte 0 and flag it.
            wr_idx    = '0;
            sof_err_d = 1'b1;
          end else begin
            wr_idx = count_q;
          end
          count_d = wr_idx + 7'd1;
          if (wr_idx == 7'(BYTES - 1)) begin
            state_d = StFull;
          end
        end
      end
      StFull: begin
        if (clear_buffer) begin
          count_d = '0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase
  end

  // Image write: byte k lands at the MSB end shifted down by 8k bits.
  always_comb begin
    img_d = img_q;
    if (accept) begin
      for (int unsigned k = 0; k < BYTES; k++) begin
        if (wr_idx == 7'(k)) begin
          img_d[IMG_BITS-1-8*k -: 8] = rx_byte;
        end
      end
    end
  end

  // State registers with synchronous reset; reset discards any image.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      img_q     <= '0;
      count_q   <= '0;
      sof_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      img_q     <= img_d;
      count_q   <= count_d;
      sof_err_q <= sof_err_d;
    end
  end

  assign img_out         = img_q;
  assign img_buffer_full = (state_q == StFull);
  assign byte_count      = count_q;
  assign sof_err         = sof_err_q;

endmodule
